// File: rtl/psum_drain.sv
// psum_drain: deskews systolic-array column partial sums and queues aligned rows for writeback (optional ReLU via PSUM_DRAIN_RELU_EN).
// Latency: a row is visible on out_data_o/out_valid_o NUM_COL cycles after its column 0 is sampled.
// Backpressure: out_ready_i may stall indefinitely; rows arriving while full are dropped and flagged on overflow_o.
module psum_drain #(
  parameter int PSUM_WIDTH = 32,
  parameter int NUM_COL    = 4,
  parameter int DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_COL*PSUM_WIDTH-1:0] psum_i,
  input  logic [NUM_COL-1:0]            psum_en_i,
  input  logic                          clear_i,
  output logic [NUM_COL*PSUM_WIDTH-1:0] out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          overflow_o,
  output logic                          skew_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = NUM_COL*PSUM_WIDTH;

  logic [RW-1:0]      al_dat;
  logic [NUM_COL-1:0] al_en;

  // Column c waits NUM_COL-c stages so every column lands together.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    localparam int STG = NUM_COL - c;
    logic [PSUM_WIDTH-1:0] dat_q [STG];
    logic                  en_q  [STG];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < STG; s++) begin
          dat_q[s] <= '0;
          en_q[s]  <= 1'b0;
        end
      end else if (clear_i) begin
        for (int s = 0; s < STG; s++) begin
          dat_q[s] <= '0;
          en_q[s]  <= 1'b0;
        end
      end else begin
        dat_q[0] <= psum_i[c*PSUM_WIDTH +: PSUM_WIDTH];
        en_q[0]  <= psum_en_i[c];
        for (int s = 1; s < STG; s++) begin
          dat_q[s] <= dat_q[s-1];
          en_q[s]  <= en_q[s-1];
        end
      end
    end

    assign al_dat[c*PSUM_WIDTH +: PSUM_WIDTH] = dat_q[STG-1];
    assign al_en[c]                           = en_q[STG-1];
  end

  logic [RW-1:0] wr_dat;
  always_comb begin
    wr_dat = al_dat;
`ifdef PSUM_DRAIN_RELU_EN
    for (int c = 0; c < NUM_COL; c++) begin
      if (al_dat[c*PSUM_WIDTH + PSUM_WIDTH - 1]) wr_dat[c*PSUM_WIDTH +: PSUM_WIDTH] = '0;
    end
`endif
  end

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q, skew_q;
  logic          push, pop, wr_ok, partial;

  assign push    = &al_en;
  assign partial = (|al_en) && !push;
  assign pop     = !empty_o && out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_ok   = push && (!full_o || pop);

  always_ff @(posedge clk) begin
    if (wr_ok && !clear_i) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      skew_q  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      skew_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !wr_ok) ovf_q  <= 1'b1;
      if (partial)        skew_q <= 1'b1;
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign out_valid_o = !empty_o;
  assign out_data_o  = empty_o ? '0 : mem[rd_ptr];
  assign overflow_o  = ovf_q;
  assign skew_err_o  = skew_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain (NUM_COL=4, DEPTH=8, PSUM_WIDTH=32): skewed rows are scheduled per start edge.
module tb_psum_drain;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] psum_i = '0;
  logic [3:0]   psum_en_i = '0;
  logic         clear_i = 1'b0;
  logic [127:0] out_data_o;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [3:0]   count_o;
  logic         full_o, empty_o, overflow_o, skew_err_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0;
  bit [127:0] slot_dat [256];
  bit [3:0]   slot_en  [256];
  logic [127:0] relu_in, relu_exp;

  psum_drain #(.PSUM_WIDTH(32), .NUM_COL(4), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .psum_en_i(psum_en_i), .clear_i(clear_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .skew_err_o(skew_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int base);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = 32'(base + c);
    return r;
  endfunction

  task automatic sched(input int t, input logic [127:0] d, input logic [3:0] m);
    slot_dat[t] = d;
    slot_en[t]  = m;
  endtask

  // Column c at edge cyc carries the row that started at edge cyc-c.
  task automatic tick();
    for (int c = 0; c < 4; c++) begin
      int idx;
      idx = cyc - c;
      psum_i[c*32 +: 32] = '0;
      psum_en_i[c]       = 1'b0;
      if (idx >= 0 && idx < 256 && slot_en[idx][c]) begin
        psum_i[c*32 +: 32] = slot_dat[idx][c*32 +: 32];
        psum_en_i[c]       = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_skew", skew_err_o, 0);
    rst_n = 1'b1;
    tick();

    // single row, lanes 10..13
    e0 = cyc;
    sched(e0, mk(10), 4'hF);
    for (int i = 0; i < 4; i++) tick();
    chk("single_notyet", out_valid_o, 0);
    tick();
    chk("single_valid", out_valid_o, 1);
    chk("single_data", out_data_o, {32'd13, 32'd12, 32'd11, 32'd10});
    chk("single_count", count_o, 1);
    out_ready_i = 1'b1;
    tick();
    chk("single_empty", empty_o, 1);
    chk("single_data0", out_data_o, 0);

    // streaming 20 back-to-back rows
    e0 = cyc;
    for (int k = 0; k < 20; k++) sched(e0 + k, mk(32'h100 + k*16), 4'hF);
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i >= 4 && i < 24) begin
        chk("stream_valid", out_valid_o, 1);
        chk("stream_data", out_data_o, mk(32'h100 + (i-4)*16));
      end
      chk("stream_cnt_le1", count_o <= 1, 1);
    end
    chk("stream_empty", empty_o, 1);
    chk("stream_ovf", overflow_o, 0);

    // fill to full, overflow on row 9
    out_ready_i = 1'b0;
    e0 = cyc;
    for (int k = 1; k <= 9; k++) sched(e0 + k - 1, mk(32'h200 + k*16), 4'hF);
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 10) begin
        chk("fill_notfull", full_o, 0);
        chk("fill_cnt7", count_o, 7);
      end
      if (i == 11) begin
        chk("fill_full", full_o, 1);
        chk("fill_cnt8", count_o, 8);
        chk("fill_noovf", overflow_o, 0);
      end
    end
    chk("ovf_set", overflow_o, 1);
    chk("ovf_cnt8", count_o, 8);
    chk("ovf_head_stable", out_data_o, mk(32'h210));
    out_ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain1_data", out_data_o, mk(32'h200 + k*16));
      tick();
    end
    chk("drain1_empty", empty_o, 1);

    // refill across the pointer wrap, then push+pop while full
    out_ready_i = 1'b0;
    e0 = cyc;
    for (int k = 11; k <= 19; k++) sched(e0 + k - 11, mk(32'h200 + k*16), 4'hF);
    for (int i = 0; i < 13; i++) begin
      if (i == 12) out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      if (i == 11) chk("refill_full", full_o, 1);
    end
    chk("pp_cnt8", count_o, 8);
    chk("pp_full", full_o, 1);
    chk("pp_head", out_data_o, mk(32'h200 + 12*16));
    out_ready_i = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      chk("drain2_data", out_data_o, mk(32'h200 + k*16));
      tick();
    end
    chk("drain2_empty", empty_o, 1);

    // skew error: column 2 enable withheld
    out_ready_i = 1'b0;
    chk("ovf_sticky", overflow_o, 1);
    e0 = cyc;
    sched(e0, mk(32'h700), 4'b1011);
    for (int i = 0; i < 4; i++) tick();
    chk("skew_notyet", skew_err_o, 0);
    tick();
    chk("skew_set", skew_err_o, 1);
    chk("skew_nowrite", count_o, 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_skew", skew_err_o, 0);
    chk("clr_ovf", overflow_o, 0);
    chk("clr_count", count_o, 0);
    chk("clr_empty", empty_o, 1);

    // sign handling: clamp only with the ReLU build
    relu_in = {32'd3, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB};
`ifdef PSUM_DRAIN_RELU_EN
    relu_exp = {32'd3, 32'd0, 32'd7, 32'd0};
`else
    relu_exp = relu_in;
`endif
    sched(cyc, relu_in, 4'hF);
    for (int i = 0; i < 5; i++) tick();
    chk("relu_valid", out_valid_o, 1);
    chk("relu_data", out_data_o, relu_exp);
    out_ready_i = 1'b1;
    tick();
    chk("relu_empty", empty_o, 1);

    // asynchronous reset mid-operation
    out_ready_i = 1'b0;
    sched(cyc, mk(32'h900), 4'hF);
    for (int i = 0; i < 5; i++) tick();
    chk("arst_pre_cnt", count_o, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", count_o, 0);
    chk("arst_valid", out_valid_o, 0);
    chk("arst_data", out_data_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_empty", empty_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
# psum_drain

Output-side collector for the MMU systolic array. Receives per-column partial sums and `psum_en` strobes from the bottom PE row, where column c lags column 0 by c cycles. Removes the skew so each output row is column-aligned, buffers rows in a small FIFO, and drains them over a valid/ready handshake toward the accumulator/writeback path.

## Interface
Parameters:
- `PSUM_WIDTH`, 32, width of one partial sum (two's complement).
- `NUM_COL`, 4, array columns; must be ≥2.
- `DEPTH`, 8, FIFO depth in rows; power of two, ≥2.

Ports:
- `clk`, input, 1, sole clock; all state on rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `psum_i`, input, NUM_COL*PSUM_WIDTH, column c occupies bits [c*PSUM_WIDTH +: PSUM_WIDTH].
- `psum_en_i`, input, NUM_COL, bit c qualifies column c of `psum_i`.
- `clear_i`, input, 1, synchronous flush.
- `out_data_o`, output, NUM_COL*PSUM_WIDTH, head row, same packing as `psum_i`.
- `out_valid_o`, output, 1, head row present.
- `out_ready_i`, input, 1, consumer accepts head row.
- `count_o`, output, clog2(DEPTH+1), rows held.
- `full_o`, output, 1, count == DEPTH.
- `empty_o`, output, 1, count == 0.
- `overflow_o`, output, 1, sticky: a row was dropped.
- `skew_err_o`, output, 1, sticky: misaligned column strobes.

## Operation
Deskew:
- Column c passes through NUM_COL−c register stages (data and enable together).
- Stage outputs are aligned; aligned row valid = AND of all aligned enables.
- OR of all aligned enables ≠ AND (partial row) → set `skew_err_o`; the partial row is discarded.

FIFO:
- push = aligned row valid; pop = `out_valid_o` && `out_ready_i`.
- Push while full with no pop: row dropped, `overflow_o` set, contents unchanged.
- Push while full with pop in the same cycle: both occur; count stays DEPTH.
- Push and pop in the same cycle at any other count: both occur; count unchanged.
- Pop when empty cannot occur, because `out_valid_o` = 0.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `out_data_o` = mem[rd_ptr] when non-empty, all zeros when empty.
- `out_valid_o` = !`empty_o`.

Clear:
- `clear_i` = 1 at an edge zeroes the delay stages, pointers, count and both sticky flags.
- It overrides push and pop in that cycle; rows in flight in the deskew stages are lost.

## Timing
- Reset (async assert, sync to clock domain on release): all stages, pointers and count = 0. Outputs: `out_valid_o` = 0, `out_data_o` = 0, `count_o` = 0, `empty_o` = 1, `full_o` = 0, `overflow_o` = 0, `skew_err_o` = 0.
- A reset asserted mid-operation discards all rows immediately.
- Row sampling: column c of row r is sampled at edge E0+c. The row reaches the aligned stage outputs after edge E0+NUM_COL−1 and is written at edge E0+NUM_COL.
- Latency: `out_valid_o` and the row's data are visible from edge E0+NUM_COL, i.e. NUM_COL cycles after column 0 is sampled.
- Throughput: one row per cycle in and one row per cycle out sustained. Back-to-back rows need no bubble.
- Flags `count_o`, `full_o`, `empty_o`, `overflow_o`, `skew_err_o` update on the same edge as the event that changes them.
- Consumer handshake: the consumer may hold `out_ready_i` low indefinitely. While `out_valid_o` = 1 and the row is not accepted, `out_data_o` is stable.

## Configuration
- Macro `PSUM_DRAIN_RELU_EN`.
- Defined: each PSUM_WIDTH lane is clamped to 0 at FIFO write when its MSB is 1; non-negative values pass unchanged.
- Undefined: values are stored and output bit-exact.
- Deskew, FIFO and latency are identical in both builds.

## Test plan
- Single row, NUM_COL=4: column c driven with value 10+c at edge E0+c → `out_valid_o` rises at E0+4 with lanes {10,11,12,13}; `count_o` = 1; a pop with `out_ready_i` = 1 returns `empty_o` = 1.
- Streaming: 20 back-to-back skewed rows with `out_ready_i` held at 1 → 20 rows out, in order, one per cycle; `count_o` ≤ 1; `overflow_o` = 0.
- Full and overflow, DEPTH=8, `out_ready_i` = 0, 9 rows → `full_o` after the 8th; the 9th is dropped and `overflow_o` = 1. Drain returns rows 1–8; pointer wrap is exercised by refilling 8 more.
- Full with simultaneous push and pop: at count = 8, assert `out_ready_i` while a row arrives → `count_o` stays 8; the popped row is the oldest and the new row is at the tail.
- Skew error: column 2 enable withheld for one row → `skew_err_o` = 1 and no row is written. Then `clear_i` → both flags = 0, `count_o` = 0.
- With `PSUM_DRAIN_RELU_EN` defined, lanes {−5, 7, 0x80000000, 3} → output {0, 7, 0, 3}. Without the macro → output equal to the input.
